key_input: RTL and testbench

KEY_INPUT -- requirements
Module: key_input

---
 rtl/key_input.sv | 114 +++++++++++
 tb/tb_key_input.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_input.sv
// key_input: per-channel synchronizer, debouncer and auto-repeat pulse generator
// for five game buttons {down, rotate, right, left, start}.
module key_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 5000000,
    parameter int unsigned REPEAT_RATE     = 1250000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter logic [4:0]  REPEAT_MASK     = 5'b10110
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_btn,
    output logic [4:0] o_level,
    output logic [4:0] o_pulse
);

    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 24;

    // Raw level of a released button; also the polarity flip applied after sync.
    localparam logic [NCH-1:0] IDLE_LVL = {NCH{ACTIVE_LOW}};
    localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]  RR_LAST  = CW'(REPEAT_RATE - 1);

    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0] stable_q, stable_d;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0] first_q, first_d;    // 1 = waiting for the first (long) repeat
    logic [CW-1:0]  db_q  [NCH];
    logic [CW-1:0]  db_d  [NCH];
    logic [CW-1:0]  rep_q [NCH];
    logic [CW-1:0]  rep_d [NCH];

    logic [NCH-1:0] sync_c;
    logic [NCH-1:0] rise_c, fall_c, hit_c;

    // Two-flop synchronizer on the raw buttons
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    assign sync_c = sync2_q ^ IDLE_LVL;

    // Debounce, edge detect and repeat scheduling, one independent lane per channel
    always_comb begin
        stable_d = stable_q;
        pulse_d  = '0;
        first_d  = '1;
        rise_c   = '0;
        fall_c   = '0;
        hit_c    = '0;
        for (int n = 0; n < NCH; n++) begin
            db_d[n]  = '0;
            rep_d[n] = '0;

            if (sync_c[n] != stable_q[n]) begin
                if (db_q[n] == DB_LAST) begin
                    stable_d[n] = ~stable_q[n];
                end else begin
                    db_d[n] = db_q[n] + CW'(1);
                end
            end

            rise_c[n] = stable_d[n] & ~stable_q[n];
            fall_c[n] = stable_q[n] & ~stable_d[n];
            hit_c[n]  = (rep_q[n] == (first_q[n] ? RD_LAST : RR_LAST));

            // Repeat counter only runs while held; a release edge wipes it
            if (REPEAT_MASK[n] && stable_q[n] && !fall_c[n]) begin
                if (hit_c[n]) begin
                    first_d[n] = 1'b0;
                end else begin
                    rep_d[n]   = rep_q[n] + CW'(1);
                    first_d[n] = first_q[n];
                end
            end

            pulse_d[n] = rise_c[n]
                       | (REPEAT_MASK[n] & stable_q[n] & ~fall_c[n] & hit_c[n]);
        end
    end

    // Per-channel state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stable_q <= '0;
            pulse_q  <= '0;
            first_q  <= '1;
            for (int n = 0; n < NCH; n++) begin
                db_q[n]  <= '0;
                rep_q[n] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            first_q  <= first_d;
            for (int n = 0; n < NCH; n++) begin
                db_q[n]  <= db_d[n];
                rep_q[n] <= rep_d[n];
            end
        end
    end

    assign o_level = stable_q;
    assign o_pulse = pulse_q;

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Cycle c means "just after rising edge c"; inputs changed at cycle 0 are seen from edge 1.
module tb_key_input;

    logic       i_clk;
    logic       i_rst;
    logic [4:0] i_btn;
    logic [4:0] o_level;
    logic [4:0] o_pulse;

    int total;
    int bad;

    key_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_MASK    (5'b10110)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn),
        .o_level(o_level),
        .o_pulse(o_pulse)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expected pulse for a repeat-enabled channel pressed at cycle 0 and held
    function automatic logic rep_exp(int x);
        return (x == 6) || (x >= 16 && ((x - 16) % 3) == 0);
    endfunction

    task automatic do_reset();
        i_btn = 5'b11111;
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_reset();
        i_btn = 5'b11111;
        i_rst = 1'b1;
        tick();
        tick();
        total++;
        if (o_level !== 5'b0) begin
            bad++;
            $display("FAIL reset_level got=%b want=%b", o_level, 5'b0);
        end
        total++;
        if (o_pulse !== 5'b0) begin
            bad++;
            $display("FAIL reset_pulse got=%b want=%b", o_pulse, 5'b0);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_press_repeat();
        logic [4:0] ep, el;
        do_reset();
        tick();
        i_btn[1] = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            ep = '0;
            el = '0;
            ep[1] = rep_exp(c) && (c < 36);
            el[1] = (c >= 6) && (c < 36);
            total++;
            if (o_pulse !== ep || o_level !== el) begin
                bad++;
                $display("FAIL press_repeat c=%0d pulse=%b/%b level=%b/%b (got/want)",
                         c, o_pulse, ep, o_level, el);
            end
            if (c == 30) i_btn[1] = 1'b1;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        tick();
        i_btn[1] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            total++;
            if (o_pulse !== 5'b0 || o_level !== 5'b0) begin
                bad++;
                $display("FAIL glitch c=%0d pulse=%b level=%b want 0", c, o_pulse, o_level);
            end
            if (c == 3) i_btn[1] = 1'b1;
        end
    endtask

    task automatic test_no_repeat();
        logic [4:0] ep, el;
        do_reset();
        tick();
        i_btn[3] = 1'b0;
        for (int c = 1; c <= 62; c++) begin
            tick();
            ep = '0;
            el = '0;
            ep[3] = (c == 6);
            el[3] = (c >= 6) && (c < 56);
            total++;
            if (o_pulse !== ep || o_level !== el) begin
                bad++;
                $display("FAIL no_repeat c=%0d pulse=%b/%b level=%b/%b (got/want)",
                         c, o_pulse, ep, o_level, el);
            end
            if (c == 50) i_btn[3] = 1'b1;
        end
    endtask

    task automatic test_two_channels();
        logic [4:0] ep;
        do_reset();
        tick();
        i_btn[1] = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            ep = '0;
            ep[1] = rep_exp(c);
            ep[2] = rep_exp(c - 5);
            total++;
            if (o_pulse !== ep) begin
                bad++;
                $display("FAIL two_channels c=%0d pulse got=%b want=%b", c, o_pulse, ep);
            end
            if (c == 5) i_btn[2] = 1'b0;
        end
        i_btn = 5'b11111;
    endtask

    task automatic test_reset_hold();
        logic [4:0] ep, el;
        do_reset();
        tick();
        i_btn[1] = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 12) i_rst = 1'b1;
            if (c == 15) i_rst = 1'b0;
            if (c > 12) begin
                ep = '0;
                el = '0;
                ep[1] = (c == 21);
                el[1] = (c >= 21);
                total++;
                if (o_pulse !== ep || o_level !== el) begin
                    bad++;
                    $display("FAIL reset_hold c=%0d pulse=%b/%b level=%b/%b (got/want)",
                             c, o_pulse, ep, o_level, el);
                end
            end
        end
        i_btn = 5'b11111;
    endtask

    task automatic test_release_on_repeat();
        logic [4:0] ep, el;
        do_reset();
        tick();
        i_btn[4] = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            tick();
            ep = '0;
            el = '0;
            ep[4] = (c == 6) || (c == 16) || (c == 19) || (c == 22);
            el[4] = (c >= 6) && (c < 25);
            total++;
            if (o_pulse !== ep || o_level !== el) begin
                bad++;
                $display("FAIL release_on_repeat c=%0d pulse=%b/%b level=%b/%b (got/want)",
                         c, o_pulse, ep, o_level, el);
            end
            if (c == 19) i_btn[4] = 1'b1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_btn = 5'b11111;
        test_reset();
        test_press_repeat();
        test_glitch();
        test_no_repeat();
        test_two_channels();
        test_reset_hold();
        test_release_on_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
